// File: rtl/umi_apb_arbiter.sv
// umi_apb_arbiter
// Shares one APB completer among N APB requesters. Each transfer is
// granted round-robin, runs alone on the completer side (one outstanding,
// no reordering), and the response is routed back to the granted requester.
//
// Handshake: the completer side is plain APB. m_psel rises for one SETUP
// cycle, then m_penable rises and the payload is held until m_pready=1 in
// ACCESS. A requester sees completion as s_pready[i]=1 only while it is the
// granted owner, still has s_psel[i] & s_penable[i] asserted, and the
// completer returns m_pready in ACCESS. s_prdata/s_pslverr[i] are valid
// only alongside that s_pready[i].
module umi_apb_arbiter #(
  parameter int N   = 2,
  parameter int RAW = 32,
  parameter int RW  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester side
  input  logic [N-1:0]          s_psel,
  input  logic [N-1:0]          s_penable,
  input  logic [N-1:0]          s_pwrite,
  input  logic [N*RAW-1:0]      s_paddr,
  input  logic [N*3-1:0]        s_pprot,
  input  logic [N*RW-1:0]       s_pwdata,
  input  logic [N*(RW/8)-1:0]   s_pstrb,
  output logic [N-1:0]          s_pready,
  output logic [RW-1:0]         s_prdata,
  output logic [N-1:0]          s_pslverr,
  // completer side
  output logic                  m_psel,
  output logic                  m_penable,
  output logic                  m_pwrite,
  output logic [RAW-1:0]        m_paddr,
  output logic [2:0]            m_pprot,
  output logic [RW-1:0]         m_pwdata,
  output logic [RW/8-1:0]       m_pstrb,
  input  logic                  m_pready,
  input  logic                  m_pslverr,
  input  logic [RW-1:0]         m_prdata,
  // arbitration status
  output logic [N-1:0]          grant,
  output logic [1:0]            dbg_state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = RW / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              m_psel_q, m_psel_d;
  logic              m_penable_q, m_penable_d;
  logic              m_pwrite_q, m_pwrite_d;
  logic [RAW-1:0]    m_paddr_q, m_paddr_d;
  logic [2:0]        m_pprot_q, m_pprot_d;
  logic [RW-1:0]     m_pwdata_q, m_pwdata_d;
  logic [SW-1:0]     m_pstrb_q, m_pstrb_d;

  logic              rr_found;
  logic [IW-1:0]     rr_win;
  int                rr_idx;

  // Round-robin pick: first requesting port scanning from ptr_q, wrapping at N.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = 0;
    for (int off = 0; off < N; off++) begin
      rr_idx = int'(ptr_q) + off;
      if (rr_idx >= N) rr_idx = rr_idx - N;
      if (!rr_found && s_psel[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx[IW-1:0];
      end
    end
  end

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    grant_d     = grant_q;
    m_psel_d    = m_psel_q;
    m_penable_d = m_penable_q;
    m_pwrite_d  = m_pwrite_q;
    m_paddr_d   = m_paddr_q;
    m_pprot_d   = m_pprot_q;
    m_pwdata_d  = m_pwdata_q;
    m_pstrb_d   = m_pstrb_q;
    case (state_q)
      ST_IDLE: begin
        m_penable_d = 1'b0;
        if (rr_found) begin
          // Payload is captured once here; later requester changes are ignored.
          state_d         = ST_SETUP;
          win_d           = rr_win;
          grant_d         = '0;
          grant_d[rr_win] = 1'b1;
          m_psel_d        = 1'b1;
          m_pwrite_d      = s_pwrite[rr_win];
          m_paddr_d       = s_paddr[rr_win*RAW +: RAW];
          m_pprot_d       = s_pprot[rr_win*3 +: 3];
          m_pwdata_d      = s_pwdata[rr_win*RW +: RW];
          m_pstrb_d       = s_pstrb[rr_win*SW +: SW];
        end else begin
          m_psel_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d     = ST_ACCESS;
        m_penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // Completion does not depend on the requester still being present,
        // so a requester that drops psel mid-transfer cannot hang the bus.
        if (m_pready) begin
          state_d     = ST_IDLE;
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          grant_d     = '0;
          if (win_q == IW'(N - 1)) ptr_d = '0;
          else                     ptr_d = win_q + 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        m_psel_d    = 1'b0;
        m_penable_d = 1'b0;
        grant_d     = '0;
      end
    endcase
  end

  // FSM state and all completer-side outputs; reset drops any in-flight transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      grant_q     <= '0;
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_paddr_q   <= '0;
      m_pprot_q   <= '0;
      m_pwdata_q  <= '0;
      m_pstrb_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      grant_q     <= grant_d;
      m_psel_q    <= m_psel_d;
      m_penable_q <= m_penable_d;
      m_pwrite_q  <= m_pwrite_d;
      m_paddr_q   <= m_paddr_d;
      m_pprot_q   <= m_pprot_d;
      m_pwdata_q  <= m_pwdata_d;
      m_pstrb_q   <= m_pstrb_d;
    end
  end

  // Response routing: only the granted, still-active requester sees completion.
  always_comb begin
    s_pready  = '0;
    s_pslverr = '0;
    s_prdata  = '0;
    if (state_q == ST_ACCESS) begin
      s_prdata = m_prdata;
      for (int i = 0; i < N; i++) begin
        s_pready[i]  = grant_q[i] & s_psel[i] & s_penable[i] & m_pready;
        s_pslverr[i] = grant_q[i] & s_psel[i] & s_penable[i] & m_pready & m_pslverr;
      end
    end
  end

  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign m_pwrite  = m_pwrite_q;
  assign m_paddr   = m_paddr_q;
  assign m_pprot   = m_pprot_q;
  assign m_pwdata  = m_pwdata_q;
  assign m_pstrb   = m_pstrb_q;
  assign grant     = grant_q;
  assign dbg_state = state_q;

endmodule
